// File: rtl/l524_clkgate_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : l524_clkgate_ctrl_pkg
// Brief   : State encodings and sizing helper for the clock-gating controller.
// Revision: 1.0 - initial release
// ============================================================================
package l524_clkgate_ctrl_pkg;

  typedef logic [1:0] cg_state_t;

  localparam cg_state_t CG_ST_RUN   = 2'd0;
  localparam cg_state_t CG_ST_DRAIN = 2'd1;
  localparam cg_state_t CG_ST_GATED = 2'd2;
  localparam cg_state_t CG_ST_WAKE  = 2'd3;

  // Counter must hold the larger of the idle and wake terminal counts.
  function automatic int cg_cnt_width(input int idle_cyc, input int wake_cyc);
    int m;
    m = (idle_cyc > wake_cyc) ? idle_cyc : wake_cyc;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/l524_clkgate_ctrl_icg_cell.sv
`default_nettype none
// ============================================================================
// Module  : l524_icg_cell
// Brief   : Latch-plus-AND integrated clock gate; pass-through under FPGA_SOURCE.
// Revision: 1.0 - initial release
// ============================================================================
module l524_icg_cell (
  input  logic clk_i,
  input  logic test_mode,
  input  logic en,
  output logic clk_o
);

`ifdef FPGA_SOURCE
  assign clk_o = clk_i;
`else
  logic en_lat;

  // Transparent while the clock is low, so the enable only changes clk_o
  // between pulses and a high pulse is never truncated.
  always_latch begin
    if (!clk_i) en_lat = en | test_mode;
  end

  assign clk_o = en_lat & clk_i;
`endif

endmodule
`default_nettype wire

// File: rtl/l524_clkgate_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : l524_clkgate_ctrl
// Brief   : Multi-channel automatic clock-gating controller with wake handshake.
// Revision: 1.0 - initial release
// ============================================================================
module l524_clkgate_ctrl
  import l524_clkgate_ctrl_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int IDLE_CYC = 8,
  parameter int WAKE_CYC = 2,
  parameter int RST_ON   = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           test_mode,
  input  logic [NCH-1:0] busy_i,
  input  logic [NCH-1:0] force_on_i,
  output logic [NCH-1:0] clk_o,
  output logic [NCH-1:0] rdy_o,
  output logic [NCH-1:0] gated_o
);

  localparam int              CW        = cg_cnt_width(IDLE_CYC, WAKE_CYC);
  localparam logic [CW-1:0]   IDLE_LAST = CW'(IDLE_CYC - 1);
  localparam logic [CW-1:0]   WAKE_LAST = CW'(WAKE_CYC - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam cg_state_t       RST_STATE = (RST_ON != 0) ? CG_ST_RUN : CG_ST_GATED;

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ch
      cg_state_t       state;
      cg_state_t       state_nxt;
      logic [CW-1:0]   cnt;
      logic [CW-1:0]   cnt_nxt;
      logic            act;
      logic            en_ch;
      logic            rdy_ch;
      logic            gated_ch;

      assign act = busy_i[g] | force_on_i[g];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          state <= RST_STATE;
          cnt   <= '0;
        end else begin
          state <= state_nxt;
          cnt   <= cnt_nxt;
        end
      end

      always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
          CG_ST_RUN: begin
            if (!act && (IDLE_CYC != 0)) begin
              if (IDLE_CYC == 1) begin
                state_nxt = CG_ST_GATED;
                cnt_nxt   = '0;
              end else begin
                state_nxt = CG_ST_DRAIN;
                cnt_nxt   = CNT_ONE;
              end
            end
          end
          CG_ST_DRAIN: begin
            // A request arriving on the terminal count cancels gating.
            if (act) begin
              state_nxt = CG_ST_RUN;
              cnt_nxt   = '0;
            end else if (cnt == IDLE_LAST) begin
              state_nxt = CG_ST_GATED;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt   = cnt + CNT_ONE;
            end
          end
          CG_ST_GATED: begin
            if (act) begin
              state_nxt = CG_ST_WAKE;
              cnt_nxt   = '0;
            end
          end
          CG_ST_WAKE: begin
            if (cnt == WAKE_LAST) begin
              state_nxt = CG_ST_RUN;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt   = cnt + CNT_ONE;
            end
          end
          default: begin
            state_nxt = RST_STATE;
            cnt_nxt   = '0;
          end
        endcase
      end

      always_comb begin
        en_ch    = 1'b1;
        rdy_ch   = 1'b0;
        gated_ch = 1'b0;
        case (state)
          CG_ST_RUN,
          CG_ST_DRAIN: rdy_ch = 1'b1;
          CG_ST_GATED: begin
            en_ch    = 1'b0;
            gated_ch = 1'b1;
          end
          default:     rdy_ch = 1'b0;
        endcase
      end

      assign rdy_o[g]   = rdy_ch;
      assign gated_o[g] = gated_ch;

      l524_icg_cell u_icg (
        .clk_i     (clk_i),
        .test_mode (test_mode),
        .en        (en_ch),
        .clk_o     (clk_o[g])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_l524_clkgate_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_l524_clkgate_ctrl
// Brief   : Directed self-checking bench for l524_clkgate_ctrl (RST_ON=1 and 0).
// Revision: 1.0 - initial release
// ============================================================================
module tb_l524_clkgate_ctrl;

  logic       clk;
  logic       rst;
  logic       test_mode;
  logic [3:0] busy;
  logic [3:0] force_on;
  logic [3:0] clk_o;
  logic [3:0] rdy;
  logic [3:0] gated;

  logic [3:0] busy_b;
  logic [3:0] force_b;
  logic [3:0] clk_o_b;
  logic [3:0] rdy_b;
  logic [3:0] gated_b;

  int checks   = 0;
  int failures = 0;

  l524_clkgate_ctrl #(.NCH(4), .IDLE_CYC(8), .WAKE_CYC(2), .RST_ON(1)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .test_mode  (test_mode),
    .busy_i     (busy),
    .force_on_i (force_on),
    .clk_o      (clk_o),
    .rdy_o      (rdy),
    .gated_o    (gated)
  );

  l524_clkgate_ctrl #(.NCH(4), .IDLE_CYC(8), .WAKE_CYC(2), .RST_ON(0)) dut_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .test_mode  (test_mode),
    .busy_i     (busy_b),
    .force_on_i (force_b),
    .clk_o      (clk_o_b),
    .rdy_o      (rdy_b),
    .gated_o    (gated_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (clock-high phase).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    test_mode = 1'b0;
    busy      = 4'h0;
    force_on  = 4'h0;
    busy_b    = 4'h0;
    force_b   = 4'h0;
    tick();
    tick();
    chk("rst_rdy",       rdy,     4'hF);
    chk("rst_gated",     gated,   4'h0);
    chk("rst_clk_o",     clk_o,   4'hF);
    chk("b_rst_gated",   gated_b, 4'hF);
    chk("b_rst_rdy",     rdy_b,   4'h0);
    chk("b_rst_clk_o",   clk_o_b, 4'h0);
    rst = 1'b0;

    // 1: idle auto-gate after 8 cycles, last pulse full width
    for (int i = 0; i < 7; i++) tick();
    chk("drain7_gated",  gated,   4'h0);
    chk("drain7_rdy",    rdy,     4'hF);
    tick();
    chk("gate_gated",    gated,   4'hF);
    chk("gate_rdy",      rdy,     4'h0);
    chk("last_pulse_hi", clk_o,   4'hF);
    #3;
    chk("last_pulse_w",  clk_o,   4'hF);
    #2;
    chk("last_pulse_lo", clk_o,   4'h0);
    tick();
    chk("stuck_low",     clk_o,   4'h0);
    chk("b_stay_gated",  gated_b, 4'hF);

    // 2: wake ch0, rdy after 3 cycles
    busy[0] = 1'b1;
    tick();
    chk("wake_rdy_c1",   rdy,     4'h0);
    chk("wake_gated_c1", gated,   4'hE);
    chk("wake_clk_c1",   clk_o,   4'h0);
    #5;
    chk("wake_clk_lo",   clk_o,   4'h0);
    tick();
    chk("wake_rdy_c2",   rdy,     4'h0);
    chk("wake_clk_c2",   clk_o,   4'h1);
    tick();
    chk("wake_rdy_c3",   rdy,     4'h1);

    // 3: ch1 busy pulse at DRAIN cnt=6 restarts the idle count
    busy[1] = 1'b1;
    tick();
    tick();
    tick();
    chk("ch1_wake_rdy",  rdy,     4'h3);
    busy[1] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("ch1_drain6",    gated,   4'hC);
    busy[1] = 1'b1;
    tick();
    busy[1] = 1'b0;
    chk("ch1_pulse_rdy", rdy,     4'h3);
    for (int i = 0; i < 7; i++) tick();
    chk("ch1_re_drain7", gated,   4'hC);
    tick();
    chk("ch1_regated",   gated,   4'hE);

    // 4: act on DRAIN terminal count wins over gating
    busy[2] = 1'b1;
    tick();
    tick();
    tick();
    chk("ch2_wake_rdy",  rdy[2],  1'b1);
    busy[2] = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    busy[2] = 1'b1;
    tick();
    chk("ch2_tc_gated",  gated[2], 1'b0);
    chk("ch2_tc_rdy",    rdy[2],   1'b1);
    busy[2] = 1'b0;
    tick();
    tick();
    chk("ch2_tc_after",  gated[2], 1'b0);

    // 5: test_mode with everything gated, then force_on on ch3
    busy[0] = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("all_gated",     gated,   4'hF);
    test_mode = 1'b1;
    tick();
    chk("tm_clk_hi",     clk_o,   4'hF);
    chk("tm_gated",      gated,   4'hF);
    chk("tm_rdy",        rdy,     4'h0);
    #5;
    chk("tm_clk_lo",     clk_o,   4'h0);
    test_mode = 1'b0;
    tick();
    chk("tm_off_clk",    clk_o,   4'h0);
    force_on[3] = 1'b1;
    tick();
    tick();
    tick();
    chk("force_rdy",     rdy,     4'h8);
    for (int i = 0; i < 20; i++) tick();
    chk("force_hold_g",  gated,   4'h7);
    chk("force_hold_c",  clk_o,   4'h8);
    force_on[3] = 1'b0;

    // 6: asynchronous reset mid-WAKE
    busy[0] = 1'b1;
    tick();
    chk("w6_gated",      gated,   4'h6);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rdy",      rdy,     4'hF);
    chk("arst_gated",    gated,   4'h0);
    chk("b_arst_gated",  gated_b, 4'hF);
    tick();
    chk("arst_clk_o",    clk_o,   4'hF);
    chk("b_arst_clk_o",  clk_o_b, 4'h0);
    rst     = 1'b0;
    busy[0] = 1'b0;
    tick();
    chk("post_rst_rdy",  rdy,     4'hF);
    chk("b_post_gated",  gated_b, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
